// File: rtl/pcie_tx_arb_pkg.sv
// Shared types for the PCIe TX arbiter: FSM states,
// source indices and AXI-stream field widths.
package pcie_tx_arb_pkg;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int USER_W = 4;

  localparam logic SRC_CPL = 1'b0;
  localparam logic SRC_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFG   = 2'd1,
    ST_SEND  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/pcie_tx_arbiter_if.sv
// AXI-stream TLP bus (tdata/tkeep/tuser/tlast/tvalid/tready).
// master drives the payload and valid; slave returns tready.
interface pcie_tx_arbiter_if;
  import pcie_tx_arb_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata, tkeep, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/pcie_tx_arb_stats.sv
// Packet/drop statistics counters for the TX arbiter.
// Ports: clk, rst, stats_clr, inc0/inc1/inc_drop -> pkt_cnt0/1, drop_cnt.
module pcie_tx_arb_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stats_clr,
  input  logic             inc0,
  input  logic             inc1,
  input  logic             inc_drop,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] drop_cnt
);

  // clear takes precedence over any same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      drop_cnt <= '0;
    end else begin
      if (inc0)
        pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (inc1)
        pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      if (inc_drop)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter of two TLP sources
// (s0 = completion engine, s1 = DMA/irq) onto the bridge TX
// port m, with TX-buffer gating and config-TLP grant between
// packets. Ports: clk, rst, link_up, s0/s1 (slave), m (master),
// tx_buf_av, tx_cfg_req/gnt, tx_err_drop, busy.
// Optional PCIE_TX_ARB_STATS_EN adds stats_clr, pkt_cnt0/1, drop_cnt.
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int MIN_BUF_AV = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                link_up,
  pcie_tx_arbiter_if.slave    s0,
  pcie_tx_arbiter_if.slave    s1,
  pcie_tx_arbiter_if.master   m,
  input  logic [5:0]          tx_buf_av,
  input  logic                tx_cfg_req,
  output logic                tx_cfg_gnt,
  input  logic                tx_err_drop,
`ifdef PCIE_TX_ARB_STATS_EN
  input  logic                stats_clr,
  output logic [CNT_W-1:0]    pkt_cnt0,
  output logic [CNT_W-1:0]    pkt_cnt1,
  output logic [CNT_W-1:0]    drop_cnt,
`endif
  output logic                busy
);

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   rr_q, rr_d;
  logic   gnt_q;

  logic              src_v;
  logic              src_last;
  logic [DATA_W-1:0] src_data;
  logic [KEEP_W-1:0] src_keep;
  logic [USER_W-1:0] src_user;
  logic              pick;
  logic              buf_ok;
  logic              fire;

  assign src_v    = sel_q ? s1.tvalid : s0.tvalid;
  assign src_last = sel_q ? s1.tlast  : s0.tlast;
  assign src_data = sel_q ? s1.tdata  : s0.tdata;
  assign src_keep = sel_q ? s1.tkeep  : s0.tkeep;
  assign src_user = sel_q ? s1.tuser  : s0.tuser;

  // both valid: the source that did not go last wins
  assign pick = (s0.tvalid && s1.tvalid) ? ~rr_q
              : (s1.tvalid ? SRC_DMA : SRC_CPL);

  assign buf_ok = tx_buf_av >= 6'(MIN_BUF_AV);

  assign fire = (state_q == ST_SEND) && src_v
             && m.tready && src_last;

  assign busy       = (state_q != ST_IDLE);
  assign tx_cfg_gnt = gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SRC_CPL;
      rr_q    <= SRC_DMA;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      gnt_q   <= (state_q == ST_CFG)
              && tx_cfg_req && link_up;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    m.tdata   = '0;
    m.tkeep   = '0;
    m.tuser   = '0;
    m.tlast   = 1'b0;
    m.tvalid  = 1'b0;
    s0.tready = 1'b0;
    s1.tready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (link_up) begin
          if (tx_cfg_req)
            state_d = ST_CFG;
          else if ((s0.tvalid || s1.tvalid) && buf_ok) begin
            sel_d   = pick;
            state_d = ST_SEND;
          end
        end
      end
      ST_CFG: begin
        if (!link_up || !tx_cfg_req)
          state_d = ST_IDLE;
      end
      ST_SEND: begin
        m.tdata  = src_data;
        m.tkeep  = src_keep;
        m.tuser  = src_user;
        m.tlast  = src_last;
        m.tvalid = src_v;
        if (sel_q)
          s1.tready = m.tready;
        else
          s0.tready = m.tready;
        // a completing last beat wins over a link drop
        if (fire) begin
          rr_d    = sel_q;
          state_d = ST_IDLE;
        end else if (!link_up)
          state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (sel_q)
          s1.tready = 1'b1;
        else
          s0.tready = 1'b1;
        if (src_v && src_last) begin
          rr_d    = sel_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PCIE_TX_ARB_STATS_EN
  pcie_tx_arb_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .stats_clr (stats_clr),
    .inc0      (fire && (sel_q == SRC_CPL)),
    .inc1      (fire && (sel_q == SRC_DMA)),
    .inc_drop  (tx_err_drop),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .drop_cnt  (drop_cnt)
  );
`else
  logic unused_drop;
  assign unused_drop = tx_err_drop;
`endif

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter: round-robin, cfg grant,
// buffer gating, backpressure, link drop, single beat, reset, stats.
module tb_pcie_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       link_up;
  logic [5:0] tx_buf_av;
  logic       tx_cfg_req;
  logic       tx_cfg_gnt;
  logic       tx_err_drop;
  logic       busy;
`ifdef PCIE_TX_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;
  logic [15:0] drop_cnt;
`endif

  pcie_tx_arbiter_if s0_if ();
  pcie_tx_arbiter_if s1_if ();
  pcie_tx_arbiter_if m_if ();

  pcie_tx_arbiter #(
    .MIN_BUF_AV (2),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .link_up     (link_up),
    .s0          (s0_if),
    .s1          (s1_if),
    .m           (m_if),
    .tx_buf_av   (tx_buf_av),
    .tx_cfg_req  (tx_cfg_req),
    .tx_cfg_gnt  (tx_cfg_gnt),
    .tx_err_drop (tx_err_drop),
`ifdef PCIE_TX_ARB_STATS_EN
    .stats_clr   (stats_clr),
    .pkt_cnt0    (pkt_cnt0),
    .pkt_cnt1    (pkt_cnt1),
    .drop_cnt    (drop_cnt),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit en   [2];
  int len  [2];
  int pkt  [2];
  int beat [2];

  function automatic logic [31:0] dat(int n, int p, int b);
    return {8'(n), 8'(p), 16'(b)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s0_if.tvalid = en[0];
    s0_if.tdata  = dat(0, pkt[0], beat[0]);
    s0_if.tlast  = (beat[0] == len[0] - 1);
    s0_if.tkeep  = s0_if.tlast ? 4'h3 : 4'hF;
    s0_if.tuser  = 4'(pkt[0]);
    s1_if.tvalid = en[1];
    s1_if.tdata  = dat(1, pkt[1], beat[1]);
    s1_if.tlast  = (beat[1] == len[1] - 1);
    s1_if.tkeep  = s1_if.tlast ? 4'h1 : 4'hF;
    s1_if.tuser  = 4'(pkt[1] + 8);
  endtask

  task automatic adv(int n);
    if (beat[n] == len[n] - 1) begin
      beat[n] = 0;
      pkt[n]++;
    end else
      beat[n]++;
  endtask

  task automatic tick();
    bit h0, h1;
    h0 = s0_if.tvalid & s0_if.tready;
    h1 = s1_if.tvalid & s1_if.tready;
    @(posedge clk);
    #1;
    if (h0) adv(0);
    if (h1) adv(1);
    drive();
    #1;
  endtask

  initial begin
    rst = 1'b1; link_up = 1'b0; tx_buf_av = '0;
    tx_cfg_req = 1'b0; tx_err_drop = 1'b0;
    m_if.tready = 1'b0;
`ifdef PCIE_TX_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; len[i] = 3; pkt[i] = 0; beat[i] = 0;
    end
    drive();
    tick();
    tick();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_gnt", tx_cfg_gnt, 0);
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_mlast", m_if.tlast, 0);
    chk("rst_mdata", m_if.tdata, 0);
    chk("rst_mkeep", m_if.tkeep, 0);
    chk("rst_muser", m_if.tuser, 0);
    chk("rst_rdy0", s0_if.tready, 0);
    chk("rst_rdy1", s1_if.tready, 0);

    // round robin: 3-beat packets, s0 first, 1-cycle gaps
    rst = 1'b0; link_up = 1'b1; tx_buf_av = 6'd10;
    m_if.tready = 1'b1;
    en[0] = 1'b1; en[1] = 1'b1;
    drive();
    #1;
    for (int k = 0; k < 16; k++) begin
      int ph, src;
      ph  = k % 4;
      src = (k / 4) % 2;
      if (ph == 0) begin
        chk("rr_gap_valid", m_if.tvalid, 0);
        chk("rr_gap_busy", busy, 0);
      end else begin
        chk("rr_valid", m_if.tvalid, 1);
        chk("rr_data", m_if.tdata, dat(src, k / 8, ph - 1));
        chk("rr_last", m_if.tlast, ph == 3);
        chk("rr_rdy0", s0_if.tready, src == 0);
        chk("rr_rdy1", s1_if.tready, src == 1);
      end
      tick();
    end
    en[0] = 1'b0; en[1] = 1'b0;
    drive();
    #1;

    // config request beats a pending s0 packet
    len[0] = 2; en[0] = 1'b1; tx_cfg_req = 1'b1;
    drive();
    #1;
    tick();
    chk("cfg_busy", busy, 1);
    chk("cfg_mvalid", m_if.tvalid, 0);
    chk("cfg_rdy0", s0_if.tready, 0);
    tick();
    chk("cfg_gnt1", tx_cfg_gnt, 1);
    tick();
    chk("cfg_gnt2", tx_cfg_gnt, 1);
    chk("cfg_mvalid2", m_if.tvalid, 0);
    tx_cfg_req = 1'b0;
    #1;
    tick();
    chk("cfg_gnt_off", tx_cfg_gnt, 0);
    chk("cfg_idle", busy, 0);
    chk("cfg_idle_mv", m_if.tvalid, 0);
    tick();
    chk("cfg_s0_valid", m_if.tvalid, 1);
    chk("cfg_s0_data", m_if.tdata, dat(0, 2, 0));
    tick();
    tick();
    chk("cfg_s0_done", busy, 0);
    en[0] = 1'b0;
    drive();
    #1;

    // buffer gating: start blocked below 2, never stalls in flight
    tx_buf_av = 6'd1; en[1] = 1'b1; len[1] = 3;
    drive();
    #1;
    tick();
    chk("buf_block", busy, 0);
    tick();
    chk("buf_block2", busy, 0);
    chk("buf_rdy1", s1_if.tready, 0);
    tx_buf_av = 6'd2;
    #1;
    tick();
    chk("buf_start", m_if.tvalid, 1);
    chk("buf_b0", m_if.tdata, dat(1, 2, 0));
    tx_buf_av = 6'd0;
    #1;
    tick();
    chk("buf_b1_valid", m_if.tvalid, 1);
    chk("buf_b1", m_if.tdata, dat(1, 2, 1));
    tick();
    chk("buf_b2", m_if.tdata, dat(1, 2, 2));
    chk("buf_b2_last", m_if.tlast, 1);
    chk("buf_b2_keep", m_if.tkeep, 4'h1);
    chk("buf_b2_user", m_if.tuser, 4'd10);
    tick();
    chk("buf_done", busy, 0);
    en[1] = 1'b0; tx_buf_av = 6'd10;
    drive();
    #1;

    // backpressure on a 4-beat s0 packet
    len[0] = 4; en[0] = 1'b1;
    drive();
    #1;
    tick();
    chk("bp_b0", m_if.tdata, dat(0, 3, 0));
    chk("bp_rdy_a", s0_if.tready, 1);
    tick();
    m_if.tready = 1'b0;
    #1;
    chk("bp_rdy_b", s0_if.tready, 0);
    chk("bp_b1", m_if.tdata, dat(0, 3, 1));
    tick();
    chk("bp_b1_hold", m_if.tdata, dat(0, 3, 1));
    chk("bp_b1_valid", m_if.tvalid, 1);
    m_if.tready = 1'b1;
    #1;
    chk("bp_rdy_c", s0_if.tready, 1);
    tick();
    m_if.tready = 1'b0;
    #1;
    chk("bp_b2", m_if.tdata, dat(0, 3, 2));
    chk("bp_rdy_d", s0_if.tready, 0);
    tick();
    chk("bp_b2_hold", m_if.tdata, dat(0, 3, 2));
    chk("bp_b2_nolast", m_if.tlast, 0);
    m_if.tready = 1'b1;
    #1;
    tick();
    chk("bp_b3", m_if.tdata, dat(0, 3, 3));
    chk("bp_b3_last", m_if.tlast, 1);
    tick();
    chk("bp_done", busy, 0);
    en[0] = 1'b0;
    drive();
    #1;

    // link drop during beat 2 of a 5-beat s0 packet
    len[0] = 5; en[0] = 1'b1;
    drive();
    #1;
    tick();
    chk("ld_b0", m_if.tdata, dat(0, 4, 0));
    tick();
    tick();
    chk("ld_b2", m_if.tdata, dat(0, 4, 2));
    link_up = 1'b0;
    #1;
    tick();
    chk("ld_flush_mv", m_if.tvalid, 0);
    chk("ld_flush_rdy", s0_if.tready, 1);
    chk("ld_flush_busy", busy, 1);
    tick();
    chk("ld_flush_mv2", m_if.tvalid, 0);
    chk("ld_flush_rdy2", s0_if.tready, 1);
    tick();
    chk("ld_idle", busy, 0);
    chk("ld_idle_rdy", s0_if.tready, 0);
    chk("ld_src_next", s0_if.tdata, dat(0, 5, 0));
    tx_cfg_req = 1'b1;
    #1;
    tick();
    chk("ld_no_grant", busy, 0);
    chk("ld_no_gnt", tx_cfg_gnt, 0);
    en[0] = 1'b0; tx_cfg_req = 1'b0; link_up = 1'b1;
    drive();
    #1;

    // single-beat s1 packet
    len[1] = 1; en[1] = 1'b1;
    drive();
    #1;
    tick();
    chk("sb_data", m_if.tdata, dat(1, 3, 0));
    chk("sb_last", m_if.tlast, 1);
    tick();
    chk("sb_done", busy, 0);
    en[1] = 1'b0;
    drive();
    #1;

    // reset mid-packet abandons it
    len[0] = 4; en[0] = 1'b1;
    drive();
    #1;
    tick();
    tick();
    chk("rmp_busy", busy, 1);
    rst = 1'b1;
    #1;
    tick();
    chk("rmp_idle", busy, 0);
    chk("rmp_mv", m_if.tvalid, 0);
    rst = 1'b0; en[0] = 1'b0; beat[0] = 0;
    drive();
    #1;

`ifdef PCIE_TX_ARB_STATS_EN
    // 5 s0 + 3 s1 single-beat packets, two drop pulses
    len[0] = 1; len[1] = 1; en[0] = 1'b1; en[1] = 1'b1;
    drive();
    #1;
    for (int k = 0; k < 16; k++) begin
      tx_err_drop = (k == 3 || k == 7);
      if (k == 12) begin
        en[1] = 1'b0;
        drive();
      end
      #1;
      tick();
    end
    tx_err_drop = 1'b0;
    en[0] = 1'b0;
    drive();
    #1;
    chk("st_cnt0", 32'(pkt_cnt0), 5);
    chk("st_cnt1", 32'(pkt_cnt1), 3);
    chk("st_drop", 32'(drop_cnt), 2);
    stats_clr = 1'b1; tx_err_drop = 1'b1;
    #1;
    tick();
    chk("st_clr0", 32'(pkt_cnt0), 0);
    chk("st_clr1", 32'(pkt_cnt1), 0);
    chk("st_clrd", 32'(drop_cnt), 0);
    stats_clr = 1'b0; tx_err_drop = 1'b0;
    #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
Name: pcie_tx_arbiter

Overview:
Shares the PCIe bridge's 32-bit AXI-stream TX port (s_axis_tx_*) between two TLP sources: source 0 is the completion engine, source 1 is the DMA/interrupt engine. Arbitration is round-robin and packet-granular. The block only starts a TLP when the core reports enough TX buffers, and it services the core's config-TLP request (tx_cfg_req/tx_cfg_gnt) between packets. It sits in the user_clk_out domain, directly in front of the bridge.

Parameters:
MIN_BUF_AV, 2, minimum tx_buf_av required to start a packet.
CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
clk  in  1  bridge user clock (user_clk_out)
rst  in  1  synchronous, active-high reset (user_reset_out)
link_up  in  1  bridge user_lnk_up
s0_tdata/s1_tdata  in  32  source TLP data
s0_tkeep/s1_tkeep  in  4  source byte enables
s0_tuser/s1_tuser  in  4  source tuser, passed through unchanged
s0_tlast/s1_tlast  in  1  source end of TLP
s0_tvalid/s1_tvalid  in  1  source valid
s0_tready/s1_tready  out  1  source ready
m_tdata  out  32  to s_axis_tx_tdata
m_tkeep  out  4  to s_axis_tx_tkeep
m_tuser  out  4  to s_axis_tx_tuser
m_tlast  out  1  to s_axis_tx_tlast
m_tvalid  out  1  to s_axis_tx_tvalid
m_tready  in  1  from s_axis_tx_tready
tx_buf_av  in  6  core free TX buffers
tx_cfg_req  in  1  core requests to send a config TLP
tx_cfg_gnt  out  1  grant to core for a config TLP
tx_err_drop  in  1  core dropped a TLP (pulse)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, rr_last=1 (source 0 wins first), tx_cfg_gnt=0, all tready=0, m_tvalid=0, m_tlast=0, m_tdata/tkeep/tuser=0, busy=0. Reset mid-packet abandons the packet immediately.
- States: IDLE, CFG, SEND, FLUSH.
- IDLE:
  - If !link_up, stay in IDLE.
  - Else if tx_cfg_req is high, go to CFG. tx_cfg_req has priority over pending user packets.
  - Else if (s0_tvalid|s1_tvalid) and tx_buf_av>=MIN_BUF_AV, latch sel and go to SEND.
  - Round-robin: if both sources are valid, sel = ~rr_last; otherwise sel is the valid source.
  - Arbitration costs exactly 1 cycle: first beat appears on m_* the cycle after entry to SEND.
- CFG:
  - tx_cfg_gnt is registered high the cycle after entry and held while tx_cfg_req stays high.
  - When tx_cfg_req goes low, deassert gnt on the next cycle and return to IDLE.
  - If link_up drops, return to IDLE with gnt=0.
- SEND:
  - m_* is driven combinationally from source[sel]. s[sel]_tready=m_tready; the other source's tready=0.
  - On m_tvalid & m_tready & m_tlast: rr_last<=sel, go to IDLE.
  - tx_cfg_req is never granted mid-packet.
  - If link_up falls mid-packet, go to FLUSH.
- FLUSH:
  - m_tvalid=0. s[sel]_tready=1, discarding beats until s[sel]_tvalid & s[sel]_tlast, then go to IDLE.
  - rr_last is updated as for a normal packet end.
- Boundaries:
  - tx_buf_av below MIN_BUF_AV blocks a new start only; it never stalls a packet in flight.
  - A single-beat TLP (tlast on the first beat) returns to IDLE after 1 SEND cycle.
  - Back-to-back packets have a 1-cycle IDLE gap between them.
  - Source signals are never modified except by gating on tvalid/tready.
  - m_tvalid is 0 in IDLE, CFG and FLUSH.

Optional Feature:
PCIE_TX_ARB_STATS_EN
- Defined: adds outputs pkt_cnt0 and pkt_cnt1 (CNT_W each) and drop_cnt (CNT_W), plus input stats_clr (1).
  - pkt_cntN increments on each completed SEND packet from source N. FLUSHed packets are not counted.
  - drop_cnt increments on each tx_err_drop cycle.
  - All counters wrap, are cleared synchronously by rst or stats_clr, and have 1-cycle update latency.
  - stats_clr wins over a simultaneous increment.
- Undefined: these ports and counters do not exist; tx_err_drop is ignored.

Decomposition:
- Package pcie_tx_arb_pkg: state encoding (IDLE, CFG, SEND, FLUSH), source index constants SRC_CPL=0 and SRC_DMA=1, AXI field widths (32/4/4).
- One sub-module, pcie_tx_arb_stats, holds the counters and is instantiated only under PCIE_TX_ARB_STATS_EN.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Round-robin: both sources hold 3-beat TLPs continuously, m_tready=1, tx_buf_av=10 -> grants alternate 0,1,0,1; each packet is 3 beats followed by a 1-cycle gap; no beat is lost or reordered.
- Config priority: tx_cfg_req=1 while s0 is valid in IDLE -> tx_cfg_gnt=1 one cycle later and stays high; s0 starts only after tx_cfg_req has dropped and gnt has gone low.
- Buffer gating: tx_buf_av=1 with s1 valid -> no start; raise tx_buf_av to 2 -> SEND begins next cycle. Dropping tx_buf_av to 0 mid-packet does not stall the packet.
- Backpressure: m_tready toggles 1,0,1,0 during a 4-beat TLP -> the source sees matching tready; m_* stays stable while m_tready=0; packet is completed intact.
- Link down mid-packet: drop link_up at beat 2 of a 5-beat s0 TLP -> m_tvalid=0, s0_tready=1 until tlast, then IDLE; no new grants while link_up=0.
- Stats (PCIE_TX_ARB_STATS_EN): send 5 s0 and 3 s1 packets and pulse tx_err_drop twice -> pkt_cnt0=5, pkt_cnt1=3, drop_cnt=2; stats_clr -> all counters read 0 the next cycle.
